// File: rtl/index_scoreboard.sv
// ---------------------------------------------------------------------------
// index_scoreboard
//
// Tracks NUM_WIRE slots as a registered occupancy vector. Binary indices
// arriving on the set port mark a slot busy, and indices on the clear port
// release it. Typical uses are a register-busy scoreboard or a free-slot
// tracker whose vector (or its inverse) feeds a priority encoder.
//
// Ports:
//   clk_i        rising-edge clock
//   arst_i       asynchronous reset, active high
//   flush_i      synchronous clear of all slots (highest priority)
//   set_index_i  slot to mark busy
//   set_valid_i  set request valid
//   set_ready_o  set can be accepted this cycle (combinational, valid-independent)
//   clr_index_i  slot to release
//   clr_valid_i  clear request valid (always accepted)
//   wire_o       registered occupancy vector, bit i = slot i busy
//   count_o      registered popcount of wire_o (0..NUM_WIRE)
//   full_o       registered, all slots busy
//   empty_o      registered, no slot busy
//   err_o        registered one-cycle pulse after an illegal request
// ---------------------------------------------------------------------------
module index_scoreboard #(
  parameter  int NUM_WIRE = 16,
  localparam int IDX_W    = $clog2(NUM_WIRE),
  localparam int CNT_W    = $clog2(NUM_WIRE + 1)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                flush_i,
  input  logic [IDX_W-1:0]    set_index_i,
  input  logic                set_valid_i,
  output logic                set_ready_o,
  input  logic [IDX_W-1:0]    clr_index_i,
  input  logic                clr_valid_i,
  output logic [NUM_WIRE-1:0] wire_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o
);

  // Every value an IDX_W-bit index can take, so out-of-range indices read a
  // zero pad bit instead of falling off the end of wire_o.
  localparam int PAD_W = 1 << IDX_W;

  logic [PAD_W-1:0]    wire_pad;
  logic [PAD_W-1:0]    set_mask;
  logic [PAD_W-1:0]    clr_mask;
  logic                set_in_range;
  logic                clr_in_range;
  logic                set_fire;
  logic                clr_fire;
  logic [NUM_WIRE-1:0] wire_d;
  logic [CNT_W-1:0]    count_d;
  logic                full_d;
  logic                empty_d;
  logic                err_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wire_pad               = '0;
    wire_pad[NUM_WIRE-1:0] = wire_o;

    set_in_range = 32'(set_index_i) < NUM_WIRE;
    clr_in_range = 32'(clr_index_i) < NUM_WIRE;

    // A busy slot is backpressure on the set port, never an error.
    set_ready_o = !flush_i && set_in_range && !wire_pad[set_index_i];
    set_fire    = set_valid_i && set_ready_o;

    // Clear legality is judged against the current vector, so a same-index
    // set and clear on a free slot still flags the clear as illegal.
    clr_fire = !flush_i && clr_valid_i && clr_in_range && wire_pad[clr_index_i];

    err_d = !flush_i &&
            ((clr_valid_i && !(clr_in_range && wire_pad[clr_index_i])) ||
             (set_valid_i && !set_in_range));

    set_mask = '0;
    clr_mask = '0;
    if (set_fire) set_mask[set_index_i] = 1'b1;
    if (clr_fire) clr_mask[clr_index_i] = 1'b1;

    if (flush_i) wire_d = '0;
    else         wire_d = (wire_o & ~clr_mask[NUM_WIRE-1:0]) | set_mask[NUM_WIRE-1:0];

    // Status flags come from next state so they register alongside wire_o.
    count_d = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      count_d = count_d + CNT_W'(wire_d[i]);
    end
    full_d  = (count_d == CNT_W'(NUM_WIRE));
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wire_o  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
      err_o   <= 1'b0;
    end else begin
      wire_o  <= wire_d;
      count_o <= count_d;
      full_o  <= full_d;
      empty_o <= empty_d;
      err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_index_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_index_scoreboard
//
// Drives a 16-slot and a 12-slot index_scoreboard from the same stimulus.
// A directed vector table and hand-written sequences cover the corner cases;
// a randomized phase compares both instances against a slot-array model.
// ---------------------------------------------------------------------------
module tb_index_scoreboard;

  logic        clk;
  logic        arst;
  logic        flush;
  logic        set_valid;
  logic        clr_valid;
  logic [3:0]  set_index;
  logic [3:0]  clr_index;

  logic        ready16, full16, empty16, err16;
  logic [15:0] wire16;
  logic [4:0]  count16;

  logic        ready12, full12, empty12, err12;
  logic [11:0] wire12;
  logic [3:0]  count12;

  int checks = 0;
  int errors = 0;

  index_scoreboard #(.NUM_WIRE(16)) dut16 (
    .clk_i(clk), .arst_i(arst), .flush_i(flush),
    .set_index_i(set_index), .set_valid_i(set_valid), .set_ready_o(ready16),
    .clr_index_i(clr_index), .clr_valid_i(clr_valid),
    .wire_o(wire16), .count_o(count16), .full_o(full16), .empty_o(empty16),
    .err_o(err16)
  );

  index_scoreboard #(.NUM_WIRE(12)) dut12 (
    .clk_i(clk), .arst_i(arst), .flush_i(flush),
    .set_index_i(set_index), .set_valid_i(set_valid), .set_ready_o(ready12),
    .clr_index_i(clr_index), .clr_valid_i(clr_valid),
    .wire_o(wire12), .count_o(count12), .full_o(full12), .empty_o(empty12),
    .err_o(err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic sv, input logic [3:0] si,
                       input logic cv, input logic [3:0] ci);
    flush     = f;
    set_valid = sv;
    set_index = si;
    clr_valid = cv;
    clr_index = ci;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: slots as a plain bit array evaluated with the block's
  // acceptance rules. Bits at or above n are always zero.
  function automatic void model_step(
    input  int          n,
    input  logic [15:0] occ,
    input  logic        f, sv,
    input  logic [3:0]  si,
    input  logic        cv,
    input  logic [3:0]  ci,
    output logic [15:0] nxt,
    output logic        rdy,
    output logic        err
  );
    int s = int'(si);
    int c = int'(ci);
    rdy = !f && (s < n) && !occ[s];
    nxt = occ;
    err = 1'b0;
    if (f) begin
      nxt = '0;
    end else begin
      if (cv && (c >= n || !occ[c])) err = 1'b1;
      if (sv && s >= n)              err = 1'b1;
      if (cv && c < n && occ[c]) nxt[c] = 1'b0;
      if (sv && rdy)             nxt[s] = 1'b1;
    end
  endfunction

  typedef struct {
    logic        f;
    logic        sv;
    logic [3:0]  si;
    logic        cv;
    logic [3:0]  ci;
    logic        exp_ready;
    logic [15:0] exp_wire;
    int          exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [15:0] m16, m12, n16, n12;
    logic        r16, r12, e16, e12;

    //          f     sv    si     cv    ci     rdy   wire      cnt err
    tbl[0]  = '{1'b0, 1'b1, 4'd2,  1'b0, 4'd0,  1'b1, 16'h0004, 1, 1'b0}; // set 2
    tbl[1]  = '{1'b0, 1'b1, 4'd2,  1'b0, 4'd0,  1'b0, 16'h0004, 1, 1'b0}; // backpressure
    tbl[2]  = '{1'b0, 1'b0, 4'd2,  1'b1, 4'd2,  1'b0, 16'h0000, 0, 1'b0}; // clear 2
    tbl[3]  = '{1'b0, 1'b1, 4'd3,  1'b0, 4'd0,  1'b1, 16'h0008, 1, 1'b0}; // set 3
    tbl[4]  = '{1'b0, 1'b1, 4'd5,  1'b1, 4'd3,  1'b1, 16'h0020, 1, 1'b0}; // set 5 + clr 3
    tbl[5]  = '{1'b0, 1'b0, 4'd5,  1'b1, 4'd5,  1'b0, 16'h0000, 0, 1'b0}; // clear 5
    tbl[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  1'b1, 16'h0000, 0, 1'b1}; // illegal clear 7
    tbl[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 16'h0000, 0, 1'b0}; // err drops
    tbl[8]  = '{1'b0, 1'b1, 4'd4,  1'b0, 4'd0,  1'b1, 16'h0010, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 16'h0030, 2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'd6,  1'b0, 4'd0,  1'b1, 16'h0070, 3, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'd7,  1'b0, 4'd0,  1'b1, 16'h00F0, 4, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'd9,  1'b1, 4'd1,  1'b0, 16'h0000, 0, 1'b0}; // flush wins
    tbl[13] = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 16'h0008, 1, 1'b1}; // same idx, free
    tbl[14] = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 16'h0000, 0, 1'b0}; // same idx, busy

    // ---- reset state ----
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    arst = 1'b1;
    #12;
    check("rst_wire",  32'(wire16),  32'h0);
    check("rst_count", 32'(count16), 32'd0);
    check("rst_full",  32'(full16),  32'd0);
    check("rst_empty", 32'(empty16), 32'd1);
    check("rst_err",   32'(err16),   32'd0);
    @(negedge clk);
    arst = 1'b0;
    check("rst_hold_empty", 32'(empty16), 32'd1);

    // ---- directed vector table on the 16-slot instance ----
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].f, tbl[i].sv, tbl[i].si, tbl[i].cv, tbl[i].ci);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(ready16), 32'(tbl[i].exp_ready));
      tick();
      check($sformatf("vec%0d_wire", i),  32'(wire16),  32'(tbl[i].exp_wire));
      check($sformatf("vec%0d_count", i), 32'(count16), 32'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_err", i),   32'(err16),   32'(tbl[i].exp_err));
      check($sformatf("vec%0d_full", i),  32'(full16),  32'(tbl[i].exp_cnt == 16));
      check($sformatf("vec%0d_empty", i), 32'(empty16), 32'(tbl[i].exp_cnt == 0));
    end

    // ---- fill every slot ----
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 1'b0, 4'd0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("fill_wire",  32'(wire16),  32'hFFFF);
    check("fill_count", 32'(count16), 32'd16);
    check("fill_full",  32'(full16),  32'd1);
    check("fill_empty", 32'(empty16), 32'd0);
    check("fill12_wire",  32'(wire12),  32'hFFF);
    check("fill12_count", 32'(count12), 32'd12);
    check("fill12_full",  32'(full12),  32'd1);
    for (int i = 0; i < 16; i++) begin
      set_index = 4'(i);
      #1;
      check($sformatf("full_ready%0d", i), 32'(ready16), 32'd0);
    end

    // ---- out-of-range set on the 12-slot instance ----
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd13, 1'b0, 4'd0);
    #1;
    check("oor12_ready", 32'(ready12), 32'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("oor12_err",   32'(err12),  32'd1);
    check("oor12_wire",  32'(wire12), 32'hFFF);
    check("oor16_err",   32'(err16),  32'd0);
    tick();
    check("oor12_err_drop", 32'(err12), 32'd0);

    // ---- clear on a full vector, then mid-cycle reset ----
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    tick();
    check("clr_full_wire",  32'(wire16),  32'hFFFE);
    check("clr_full_count", 32'(count16), 32'd15);
    check("clr_full_full",  32'(full16),  32'd0);
    drive(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    #2;
    arst = 1'b1;
    #1;
    check("midrst_wire",   32'(wire16),  32'h0);
    check("midrst_empty",  32'(empty16), 32'd1);
    check("midrst_count",  32'(count16), 32'd0);
    check("midrst_wire12", 32'(wire12),  32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    arst = 1'b0;
    tick();
    check("postrst_wire", 32'(wire16), 32'h0);

    // ---- randomized phase against the model ----
    m16 = '0;
    m12 = '0;
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)));
      model_step(16, m16, flush, set_valid, set_index, clr_valid, clr_index, n16, r16, e16);
      model_step(12, m12, flush, set_valid, set_index, clr_valid, clr_index, n12, r12, e12);
      #1;
      check("rnd_ready16", 32'(ready16), 32'(r16));
      check("rnd_ready12", 32'(ready12), 32'(r12));
      tick();
      m16 = n16;
      m12 = n12;
      check("rnd_wire16",  32'(wire16),  32'(m16));
      check("rnd_count16", 32'(count16), 32'($countones(m16)));
      check("rnd_full16",  32'(full16),  32'($countones(m16) == 16));
      check("rnd_empty16", 32'(empty16), 32'(m16 == 0));
      check("rnd_err16",   32'(err16),   32'(e16));
      check("rnd_wire12",  32'(wire12),  32'(m12[11:0]));
      check("rnd_count12", 32'(count12), 32'($countones(m12)));
      check("rnd_full12",  32'(full12),  32'($countones(m12) == 12));
      check("rnd_empty12", 32'(empty12), 32'(m12 == 0));
      check("rnd_err12",   32'(err12),   32'(e12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/index_scoreboard.md
Name: index_scoreboard

Overview:
- Sequential index-to-vector block: accepts binary indices on set/clear request ports, decodes each to a one-hot bit and maintains a registered occupancy vector.
- Upstream logic feeds the vector (or its inverse) into priority_encoder, for example to find the lowest free slot, and later returns the index through the clear port.
- Typical uses: register-busy scoreboard and free-slot tracker.

Parameters:
- NUM_WIRE, 16, number of tracked slots; must be at least 2. Need not be a power of two.
- IDX_W, $clog2(NUM_WIRE), index width. Derived; never overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_i  input  1  asynchronous reset, active high.
- flush_i  input  1  synchronous clear of all slots.
- set_index_i  input  IDX_W  index of the slot to mark busy.
- set_valid_i  input  1  set request valid.
- set_ready_o  output  1  set request can be accepted this cycle.
- clr_index_i  input  IDX_W  index of the slot to release.
- clr_valid_i  input  1  clear request valid; a clear is always accepted.
- wire_o  output  NUM_WIRE  registered occupancy vector; bit i = 1 means slot i is busy.
- count_o  output  $clog2(NUM_WIRE+1)  registered popcount of wire_o.
- full_o  output  1  all NUM_WIRE bits set (registered).
- empty_o  output  1  no bits set (registered).
- err_o  output  1  registered one-cycle pulse on an illegal request.

Behaviour:
- Reset (arst_i high, asynchronous):
  - wire_o=0, count_o=0, full_o=0, empty_o=1, err_o=0.
  - Outputs hold these values until the first clock edge after arst_i deasserts.
- set_ready_o (combinational) = !flush_i && (set_index_i < NUM_WIRE) && !wire_o[set_index_i].
  - It never depends on set_valid_i.
- Set accept: set_valid_i && set_ready_o at a rising edge.
  - wire_o[set_index_i] is 1 from the next cycle (latency 1).
- Clear: clr_valid_i with clr_index_i < NUM_WIRE and the bit set.
  - The bit is 0 from the next cycle.
- Same cycle, same index:
  - Bit currently set: set_ready_o is 0, the clear proceeds, and the bit is 0 next cycle.
  - Bit currently clear: the set is accepted; the clear targets an unset bit, so err_o pulses and the bit is 1 next cycle.
- Same cycle, different indices: both take effect in the same edge, and count_o is unchanged.
- flush_i has highest priority:
  - Next cycle wire_o=0 and count_o=0.
  - set_ready_o is 0 during flush, so no set is accepted.
  - Clears during flush are ignored and never raise err_o.
- err_o pulses for exactly one cycle (registered, the cycle after the request) when either of these occurs outside flush:
  - clr_valid_i targets an unset bit, or clr_index_i >= NUM_WIRE;
  - set_valid_i with set_index_i >= NUM_WIRE.
  - A set to an already-busy bit is backpressure, not an error.
  - Illegal requests never modify state.
- Register consistency:
  - count_o, full_o and empty_o are computed from next-state and registered in the same edge as wire_o.
  - They are never one cycle stale.
- Wrap and range:
  - count_o spans 0..NUM_WIRE inclusive and never overflows.
  - With NUM_WIRE non-power-of-two, out-of-range indices are rejected as above.
- Reset mid-operation: asserting arst_i during an active set handshake discards it; the state returns to reset values immediately.
- No X propagation: when a valid is low, the corresponding index is ignored.

Test Plan:
- Reset then fill (NUM_WIRE=16): set indices 0..15 one per cycle with valid high.
  - Required: wire_o reaches 16'hFFFF, count_o=16, full_o=1, empty_o=0.
  - Required: set_ready_o=0 for every index afterwards.
- Backpressure: with wire_o=16'h0004, present set_index_i=2 with valid.
  - Required: set_ready_o=0, wire_o unchanged, err_o=0.
- Simultaneous set 5 and clear 3 from wire_o=16'h0008.
  - Required next cycle: wire_o=16'h0020, count_o=1.
- Illegal clear: clear index 7 from wire_o=0.
  - Required: err_o=1 for exactly one cycle, wire_o=0, empty_o=1.
- Flush with concurrent set 9 from wire_o=16'h00F0.
  - Required: set_ready_o=0 that cycle; next cycle wire_o=0, count_o=0, err_o=0.
- NUM_WIRE=12: set index 13.
  - Required: set_ready_o=0, err_o pulse, state unchanged.
- Mid-run reset: assert arst_i asynchronously between edges.
  - Required: wire_o=0 and empty_o=1 immediately, before the next edge.
